// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock/tick generator: registered divided clock, period-start
// tick strobe, and a valid/ready port that swaps period/high-time at period boundaries.
module prog_clk_divider #(
    parameter int WIDTH        = 32,
    parameter int DEFAULT_DIV  = 100000000,
    parameter int DEFAULT_HIGH = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] count_out
);

    // Handshake: a configuration transfers on any rising clk edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is low exactly while a configuration is pending.

    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);
    localparam logic             CLK_RST  = (DEFAULT_HIGH != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_cur;
    logic [WIDTH-1:0] high_cur;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] high_pend;

    logic             wrap;
    logic             accept;
    logic             cfg_legal;
    logic             apply;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0] high_nxt;

    assign wrap      = (count == div_cur - WIDTH'(1));
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_div >= WIDTH'(2));
    // A pending config lands at the next wrap while counting, or immediately when idle.
    assign apply     = (state == S_PEND) && (!en || wrap);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && cfg_legal) state_nxt = S_PEND;
            S_PEND: if (apply) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cfg_ready = (state == S_IDLE);
    end

    always_comb begin
        count_nxt = count;
        div_nxt   = div_cur;
        high_nxt  = high_cur;
        if (en) begin
            count_nxt = wrap ? '0 : count + WIDTH'(1);
        end
        if (apply) begin
            count_nxt = '0;
            div_nxt   = div_pend;
            high_nxt  = high_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            div_cur   <= DIV_RST;
            high_cur  <= HIGH_RST;
            div_pend  <= '0;
            high_pend <= '0;
            cfg_err   <= 1'b0;
            tick      <= 1'b0;
            clk_out   <= CLK_RST;
        end else begin
            count    <= count_nxt;
            div_cur  <= div_nxt;
            high_cur <= high_nxt;
            tick     <= en && wrap;
            cfg_err  <= accept && !cfg_legal;
            // Derived from next-state values so clk_out always equals (count < high_cur).
            clk_out  <= (count_nxt < high_nxt);
            if (accept && cfg_legal) begin
                div_pend  <= cfg_div;
                high_pend <= cfg_high;
            end
        end
    end

    assign count_out = count;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed-vector bench for prog_clk_divider (WIDTH=8, div 4, high 2 defaults):
// the driver pushes hand-computed post-edge outputs, a monitor pops and compares.
module tb_prog_clk_divider;

    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic [WIDTH-1:0] cfg_high;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] count_out;

    logic [EW-1:0] exp_q[$];
    int            id_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            vec_id   = 0;

    prog_clk_divider #(
        .WIDTH(WIDTH),
        .DEFAULT_DIV(4),
        .DEFAULT_HIGH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div(cfg_div),
        .cfg_high(cfg_high),
        .cfg_err(cfg_err),
        .clk_out(clk_out),
        .tick(tick),
        .count_out(count_out)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: inputs for the coming edge plus the outputs expected right after it.
    task automatic step(input logic r, input logic e, input logic v,
                        input int div, input int high,
                        input int x_cnt, input logic x_clk, input logic x_tick,
                        input logic x_rdy, input logic x_err);
        @(negedge clk);
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_div   = WIDTH'(div);
        cfg_high  = WIDTH'(high);
        exp_q.push_back({WIDTH'(x_cnt), x_clk, x_tick, x_rdy, x_err});
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    task automatic run(input logic e, input int x_cnt, input logic x_clk, input logic x_tick,
                       input logic x_rdy);
        step(1'b0, e, 1'b0, 0, 0, x_cnt, x_clk, x_tick, x_rdy, 1'b0);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        int            id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                id  = id_q.pop_front();
                got = {count_out, clk_out, tick, cfg_ready, cfg_err};
                n_checks++;
                if (got === exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL vec%0d: got count=%0d clk_out=%b tick=%b rdy=%b err=%b, want count=%0d clk_out=%b tick=%b rdy=%b err=%b",
                             id, got[EW-1:4], got[3], got[2], got[1], got[0],
                             exp[EW-1:4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;

        // Reset state, then default div 4 / high 2 pattern
        step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        for (int p = 0; p < 2; p++) begin
            run(1, 1, 1, 0, 1);
            run(1, 2, 0, 0, 1);
            run(1, 3, 0, 0, 1);
            run(1, 0, 1, 1, 1);
        end
        run(1, 1, 1, 0, 1);

        // div 5 / high 1 offered at count 1; old period completes first
        step(0, 1, 1, 5, 1, 2, 0, 0, 0, 0);
        run(1, 3, 0, 0, 0);
        run(1, 0, 1, 1, 1);
        run(1, 1, 0, 0, 1);
        run(1, 2, 0, 0, 1);
        run(1, 3, 0, 0, 1);
        run(1, 4, 0, 0, 1);
        run(1, 0, 1, 1, 1);
        run(1, 1, 0, 0, 1);

        // Illegal divisors 1 and 0: error pulse, pattern unchanged
        step(0, 1, 1, 1, 3, 2, 0, 0, 1, 1);
        run(1, 3, 0, 0, 1);
        step(0, 1, 1, 0, 3, 4, 0, 0, 1, 1);
        run(1, 0, 1, 1, 1);
        run(1, 1, 0, 0, 1);

        // high 0 -> constant low
        step(0, 1, 1, 5, 0, 2, 0, 0, 0, 0);
        run(1, 3, 0, 0, 0);
        run(1, 4, 0, 0, 0);
        run(1, 0, 0, 1, 1);
        for (int c = 1; c < 5; c++) run(1, c, 0, 0, 1);
        run(1, 0, 0, 1, 1);

        // high 7 >= div 5 -> constant high
        step(0, 1, 1, 5, 7, 1, 0, 0, 0, 0);
        for (int c = 2; c < 5; c++) run(1, c, 0, 0, 0);
        run(1, 0, 1, 1, 1);
        for (int c = 1; c < 5; c++) run(1, c, 1, 0, 1);

        // Offer in the wrap cycle: wrap uses old config, div 3 / high 1 at next wrap
        step(0, 1, 1, 3, 1, 0, 1, 1, 0, 0);
        for (int c = 1; c < 5; c++) run(1, c, 1, 0, 0);
        run(1, 0, 1, 1, 1);
        run(1, 1, 0, 0, 1);
        run(1, 2, 0, 0, 1);
        run(1, 0, 1, 1, 1);

        // en low at count 2 holds; config accepted while disabled applies at once
        run(1, 1, 0, 0, 1);
        run(1, 2, 0, 0, 1);
        run(0, 2, 0, 0, 1);
        run(0, 2, 0, 0, 1);
        step(0, 0, 1, 3, 1, 2, 0, 0, 0, 0);
        run(0, 0, 1, 0, 1);
        run(0, 0, 1, 0, 1);
        run(1, 1, 0, 0, 1);
        run(1, 2, 0, 0, 1);
        run(1, 0, 1, 1, 1);

        // Pending div 6 / high 6 discarded by reset mid-period
        step(0, 1, 1, 6, 6, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        run(1, 1, 1, 0, 1);
        run(1, 2, 0, 0, 1);
        run(1, 3, 0, 0, 1);
        run(1, 0, 1, 1, 1);

        // Pending config while disabled; reset with cfg_valid high wins
        step(0, 0, 1, 7, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 7, 0, 0, 1, 0, 1, 0);
        run(1, 1, 1, 0, 1);
        run(1, 2, 0, 0, 1);
        run(1, 3, 0, 0, 1);
        run(1, 0, 1, 1, 1);

        @(negedge clk);
        cfg_valid = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
